pipelined_carry_adder: RTL

- Parametrised successor to the single-bit full adder: WIDTH-bit adder with Cin.
- The carry chain is split into SEG_W-bit ripple segments, one register stage per segment.
- Valid/ready handshake on input and output. Full throughput of 1 add/cycle, latency STAGES cycles.
- Used by datapath blocks that need wide adds at a clock rate a flat ripple chain cannot meet.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_segment.sv | 31 +++
 rtl/pipelined_carry_adder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, the per-stage control bundle and the
// stage-count helper for the pipelined carry adder.
package adder_pkg;

    localparam int ADDER_WIDTH_DEF = 16;
    localparam int ADDER_SEG_W_DEF = 4;

    // Control carried alongside each pipeline stage: occupancy and the
    // carry into the next segment still to be resolved.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    // Number of ripple segments (and register stages). Guarded so that an
    // illegal SEG_W still elaborates far enough to hit the parameter check.
    function automatic int stages_f(input int width, input int seg_w);
        if (seg_w < 1 || width < seg_w) begin
            return 1;
        end
        return width / seg_w;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// adder_segment: SEG_W-bit combinational ripple of full adders. Also exposes
// the carry into its top bit so the top segment can flag signed overflow.
module adder_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SEG_W:0] carry;

    // Ripple the carry bit by bit through the segment.
    always_comb begin
        // NOTE: every output of a comb block gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < SEG_W; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        co    = carry[SEG_W];
        c_msb = carry[SEG_W-1];
    end

endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit A+B+Cin with the carry chain cut into
// SEG_W-bit ripple segments, one register stage per segment, valid/ready on
// both sides with bubble-collapsing backpressure. Latency STAGES cycles,
// throughput one add per cycle.
// Optional: define ADDER_OVF_FLAG_EN to add a registered signed-overflow
// output `ovf` aligned with Sum.
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEF,
    parameter int SEG_W = ADDER_SEG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
`ifdef ADDER_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             Cout
);

    localparam int STAGES = stages_f(WIDTH, SEG_W);

    if ((SEG_W < 1) || (WIDTH < SEG_W) || ((WIDTH % ((SEG_W < 1) ? 1 : SEG_W)) != 0))
    begin : g_param_err
        $error("pipelined_carry_adder: WIDTH (%0d) must be a positive multiple of SEG_W (%0d)",
               WIDTH, SEG_W);
    end

    // Stage k register holds the result after segment k was resolved:
    // sum bits [(k+1)*SEG_W-1:0], carry into segment k+1, and the operands
    // whose upper bits the following stages still need.
    stage_ctl_t       ctl_q [STAGES];
    stage_ctl_t       ctl_d [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];

    logic [SEG_W-1:0] seg_a    [STAGES];
    logic [SEG_W-1:0] seg_b    [STAGES];
    logic [SEG_W-1:0] seg_s    [STAGES];
    logic             seg_ci   [STAGES];
    logic             seg_co   [STAGES];
    logic             seg_cmsb [STAGES];

    logic [STAGES-1:0] stage_ready;
    logic              unused_bits;

    // Segment k resolves bits [(k+1)*SEG_W-1:k*SEG_W]; segment 0 works on
    // the live inputs, the rest on the previous stage register.
    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign seg_a[k]  = A[SEG_W-1:0];
            assign seg_b[k]  = B[SEG_W-1:0];
            assign seg_ci[k] = Cin;
        end else begin : g_rest
            assign seg_a[k]  = a_q[k-1][k*SEG_W +: SEG_W];
            assign seg_b[k]  = b_q[k-1][k*SEG_W +: SEG_W];
            assign seg_ci[k] = ctl_q[k-1].carry;
        end

        adder_segment #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a     (seg_a[k]),
            .b     (seg_b[k]),
            .ci    (seg_ci[k]),
            .s     (seg_s[k]),
            .co    (seg_co[k]),
            .c_msb (seg_cmsb[k])
        );
    end

    // A stage may load when it is empty or everything downstream can move;
    // unrolled from the flop valids so no comb path runs through itself.
    always_comb begin
        stage_ready = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_ready[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!ctl_q[j].valid) begin
                    stage_ready[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = stage_ready[0];

    // Advance each stage that is ready; a stage that is not ready holds.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ctl_d[k] = ctl_q[k];
            sum_d[k] = sum_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
        end

        if (stage_ready[0]) begin
            ctl_d[0].valid       = in_valid;
            ctl_d[0].carry       = seg_co[0];
            sum_d[0]             = '0;
            sum_d[0][SEG_W-1:0]  = seg_s[0];
            a_d[0]               = A;
            b_d[0]               = B;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (stage_ready[k]) begin
                ctl_d[k].valid                = ctl_q[k-1].valid;
                ctl_d[k].carry                = seg_co[k];
                sum_d[k]                      = sum_q[k-1];
                sum_d[k][k*SEG_W +: SEG_W]    = seg_s[k];
                a_d[k]                        = a_q[k-1];
                b_d[k]                        = b_q[k-1];
            end
        end
    end

    // Pipeline registers; reset empties the pipe and clears the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                // NOTE: pipeline data is reset too, not just the valids, so
                // Sum/Cout read 0 during and right after reset.
                ctl_q[k] <= '0;
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                // NOTE: non-blocking so every stage samples its neighbour's
                // pre-edge value and data moves exactly one stage per clock.
                ctl_q[k] <= ctl_d[k];
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

`ifdef ADDER_OVF_FLAG_EN
    logic ovf_q;
    logic ovf_d;

    // Overflow of the top segment, captured with the final stage.
    always_comb begin
        ovf_d = ovf_q;
        if (stage_ready[STAGES-1]) begin
            ovf_d = seg_cmsb[STAGES-1] ^ seg_co[STAGES-1];
        end
    end

    // Overflow flag register, same enable and reset as the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Operand bits below the resolved point are dead after each stage;
    // fold them (and unused top-bit carries) into a sink.
    always_comb begin
        unused_bits = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_bits = unused_bits ^ (^a_q[k]) ^ (^b_q[k]) ^ seg_cmsb[k];
        end
    end

    assign out_valid = ctl_q[STAGES-1].valid;
    assign Sum       = sum_q[STAGES-1];
    assign Cout      = ctl_q[STAGES-1].carry;

endmodule
